// File: rtl/wf8_pkg.sv
// rtl/wf8_pkg.sv - shared constants and state encoding for the bus sequencer
package wf8_pkg;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 8;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b01;
  localparam logic [1:0] OP_LDI = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam logic [2:0] ALU_PASS = 3'd7;
  localparam logic [2:0] ACC_IDX  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    XFER,
    ALU_RD,
    ALU_WB,
    IMM_WAIT,
    IMM_WR
  } state_t;

endpackage

// File: rtl/bus_sequencer_if.sv
// rtl/bus_sequencer_if.sv - fetch handshake and datapath control bundle
interface bus_sequencer_if;
  import wf8_pkg::*;

  logic                instr_valid;
  logic [DATA_W-1:0]   instr_data;
  logic                instr_ready;
  logic [NUM_REGS-1:0] xxx_write_en;
  logic [NUM_REGS-1:0] xxx_read_en;
  logic                imm_drive;
  logic [DATA_W-1:0]   imm_data;
  logic                alu_b_load;
  logic [2:0]          alu_op;
  logic                busy;

  modport master (
    output instr_valid, instr_data,
    input  instr_ready, xxx_write_en, xxx_read_en, imm_drive, imm_data,
    input  alu_b_load, alu_op, busy
  );

  modport slave (
    input  instr_valid, instr_data,
    output instr_ready, xxx_write_en, xxx_read_en, imm_drive, imm_data,
    output alu_b_load, alu_op, busy
  );

endinterface

// File: rtl/bus_sequencer_idx_decode.sv
// rtl/bus_sequencer_idx_decode.sv - 3-bit index plus enable to 8-bit one-hot
module idx_decode (
  input  logic       en,
  input  logic [2:0] idx,
  output logic [7:0] onehot
);

  assign onehot = en ? (8'd1 << idx) : 8'd0;

endmodule

// File: rtl/bus_sequencer.sv
// rtl/bus_sequencer.sv - byte-stream instruction sequencer driving register file, immediate and ALU strobes
module bus_sequencer
  import wf8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  bus_sequencer_if.slave bus
);

  state_t            state, state_n;
  logic [2:0]        rd_q, rd_n;
  logic [2:0]        rs_q, rs_n;
  logic [2:0]        func_q, func_n;
  logic [DATA_W-1:0] imm_q, imm_n;

  logic       accept;
  logic       rd_strobe;
  logic       wr_strobe;
  logic [2:0] wr_idx;
  logic       imm_drive_c;
  logic       b_load_c;

  assign bus.instr_ready = (state == IDLE) || (state == IMM_WAIT);
  assign accept          = bus.instr_valid && bus.instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rd_q   <= 3'd0;
      rs_q   <= 3'd0;
      func_q <= 3'd0;
      imm_q  <= '0;
    end else begin
      state  <= state_n;
      rd_q   <= rd_n;
      rs_q   <= rs_n;
      func_q <= func_n;
      imm_q  <= imm_n;
    end
  end

  // Strobes are pure decodes of the registered state, so they land one cycle after acceptance.
  always_comb begin
    state_n     = state;
    rd_n        = rd_q;
    rs_n        = rs_q;
    func_n      = func_q;
    imm_n       = imm_q;
    rd_strobe   = 1'b0;
    wr_strobe   = 1'b0;
    wr_idx      = rd_q;
    imm_drive_c = 1'b0;
    b_load_c    = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.instr_data[7:6])
            OP_MOV: begin
              rs_n = bus.instr_data[2:0];
              // A move into the accumulator has to go through the ALU as PASS B.
              if (bus.instr_data[5:3] == ACC_IDX) begin
                func_n  = ALU_PASS;
                state_n = ALU_RD;
              end else begin
                rd_n    = bus.instr_data[5:3];
                state_n = XFER;
              end
            end
            OP_ALU: begin
              func_n  = bus.instr_data[5:3];
              rs_n    = bus.instr_data[2:0];
              state_n = ALU_RD;
            end
            OP_LDI: begin
              rd_n    = bus.instr_data[5:3];
              func_n  = ALU_PASS;
              state_n = IMM_WAIT;
            end
            OP_NOP: ;
            default: ;
          endcase
        end
      end
      XFER: begin
        rd_strobe = (rs_q != rd_q);
        wr_strobe = (rs_q != rd_q);
        state_n   = IDLE;
      end
      ALU_RD: begin
        rd_strobe = 1'b1;
        b_load_c  = 1'b1;
        state_n   = ALU_WB;
      end
      ALU_WB: begin
        wr_strobe = 1'b1;
        wr_idx    = ACC_IDX;
        state_n   = IDLE;
      end
      IMM_WAIT: begin
        if (accept) begin
          imm_n   = bus.instr_data;
          state_n = IMM_WR;
        end
      end
      IMM_WR: begin
        imm_drive_c = 1'b1;
        if (rd_q == ACC_IDX) begin
          b_load_c = 1'b1;
          state_n  = ALU_WB;
        end else begin
          wr_strobe = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  idx_decode u_read_dec (
    .en     (rd_strobe),
    .idx    (rs_q),
    .onehot (bus.xxx_read_en)
  );

  idx_decode u_write_dec (
    .en     (wr_strobe),
    .idx    (wr_idx),
    .onehot (bus.xxx_write_en)
  );

  assign bus.imm_drive  = imm_drive_c;
  assign bus.alu_b_load = b_load_c;
  assign bus.alu_op     = func_q;
  assign bus.imm_data   = imm_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_bus_sequencer.sv
// tb/tb_bus_sequencer.sv - directed and random-stream bench for bus_sequencer
module tb_bus_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bus_sequencer_if bus ();

  bus_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.instr_valid = 1'b1;
    bus.instr_data  = b;
    step();
    bus.instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_data  = 8'h0A;
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.instr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.instr_ready); end
    checks++; if (bus.xxx_read_en !== 8'h00 || bus.xxx_write_en !== 8'h00) begin failures++; $display("FAIL reset_strobes got rd=%h wr=%h exp 00/00", bus.xxx_read_en, bus.xxx_write_en); end
    checks++; if (bus.alu_op !== 3'd0 || bus.imm_data !== 8'h00 || bus.imm_drive !== 1'b0 || bus.alu_b_load !== 1'b0) begin failures++; $display("FAIL reset_regs got op=%0d imm=%h drv=%b bl=%b exp 0/00/0/0", bus.alu_op, bus.imm_data, bus.imm_drive, bus.alu_b_load); end
    bus.instr_valid = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (bus.busy !== 1'b0 || bus.xxx_read_en !== 8'h00) begin failures++; $display("FAIL reset_no_accept got busy=%b rd=%h exp 0/00", bus.busy, bus.xxx_read_en); end
  endtask

  task automatic test_mov();
    send(8'h0A);
    checks++; if (bus.xxx_read_en !== 8'h04 || bus.xxx_write_en !== 8'h02) begin failures++; $display("FAIL mov_strobes got rd=%h wr=%h exp 04/02", bus.xxx_read_en, bus.xxx_write_en); end
    checks++; if (bus.instr_ready !== 1'b0 || bus.busy !== 1'b1) begin failures++; $display("FAIL mov_xfer_flags got rdy=%b busy=%b exp 0/1", bus.instr_ready, bus.busy); end
    step();
    checks++; if (bus.xxx_read_en !== 8'h00 || bus.xxx_write_en !== 8'h00 || bus.instr_ready !== 1'b1) begin failures++; $display("FAIL mov_done got rd=%h wr=%h rdy=%b exp 00/00/1", bus.xxx_read_en, bus.xxx_write_en, bus.instr_ready); end
  endtask

  task automatic test_mov_same();
    send(8'h09);
    checks++; if (bus.busy !== 1'b1 || bus.xxx_read_en !== 8'h00 || bus.xxx_write_en !== 8'h00) begin failures++; $display("FAIL mov_same got busy=%b rd=%h wr=%h exp 1/00/00", bus.busy, bus.xxx_read_en, bus.xxx_write_en); end
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mov_same_idle got busy=%b exp 0", bus.busy); end
  endtask

  task automatic test_alu();
    send(8'h5B);
    checks++; if (bus.xxx_read_en !== 8'h08 || bus.alu_b_load !== 1'b1 || bus.alu_op !== 3'd3 || bus.xxx_write_en !== 8'h00) begin failures++; $display("FAIL alu_rd got rd=%h bl=%b op=%0d wr=%h exp 08/1/3/00", bus.xxx_read_en, bus.alu_b_load, bus.alu_op, bus.xxx_write_en); end
    step();
    checks++; if (bus.xxx_write_en !== 8'h80 || bus.xxx_read_en !== 8'h00 || bus.alu_op !== 3'd3 || bus.alu_b_load !== 1'b0) begin failures++; $display("FAIL alu_wb got wr=%h rd=%h op=%0d bl=%b exp 80/00/3/0", bus.xxx_write_en, bus.xxx_read_en, bus.alu_op, bus.alu_b_load); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.xxx_write_en !== 8'h00) begin failures++; $display("FAIL alu_idle got busy=%b wr=%h exp 0/00", bus.busy, bus.xxx_write_en); end
  endtask

  task automatic test_ldi();
    send(8'h88);
    checks++; if (bus.busy !== 1'b1 || bus.instr_ready !== 1'b1) begin failures++; $display("FAIL ldi_wait got busy=%b rdy=%b exp 1/1", bus.busy, bus.instr_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (bus.busy !== 1'b1 || bus.xxx_write_en !== 8'h00 || bus.xxx_read_en !== 8'h00 || bus.imm_drive !== 1'b0) begin failures++; $display("FAIL ldi_hold%0d got busy=%b wr=%h rd=%h drv=%b exp 1/00/00/0", i, bus.busy, bus.xxx_write_en, bus.xxx_read_en, bus.imm_drive); end
    end
    send(8'hA5);
    checks++; if (bus.imm_data !== 8'hA5 || bus.imm_drive !== 1'b1 || bus.xxx_write_en !== 8'h02 || bus.xxx_read_en !== 8'h00) begin failures++; $display("FAIL ldi_wr got imm=%h drv=%b wr=%h rd=%h exp A5/1/02/00", bus.imm_data, bus.imm_drive, bus.xxx_write_en, bus.xxx_read_en); end
    step();
    checks++; if (bus.busy !== 1'b0 || bus.imm_drive !== 1'b0) begin failures++; $display("FAIL ldi_idle got busy=%b drv=%b exp 0/0", bus.busy, bus.imm_drive); end
  endtask

  task automatic test_mov_acc();
    send(8'h3D);
    checks++; if (bus.xxx_read_en !== 8'h20 || bus.alu_b_load !== 1'b1 || bus.alu_op !== 3'd7 || bus.xxx_write_en !== 8'h00) begin failures++; $display("FAIL movacc_rd got rd=%h bl=%b op=%0d wr=%h exp 20/1/7/00", bus.xxx_read_en, bus.alu_b_load, bus.alu_op, bus.xxx_write_en); end
    step();
    checks++; if (bus.xxx_write_en !== 8'h80 || bus.xxx_read_en !== 8'h00) begin failures++; $display("FAIL movacc_wb got wr=%h rd=%h exp 80/00", bus.xxx_write_en, bus.xxx_read_en); end
    step();
  endtask

  task automatic test_ldi_acc();
    send(8'hB8);
    send(8'h3C);
    checks++; if (bus.imm_data !== 8'h3C || bus.imm_drive !== 1'b1 || bus.alu_b_load !== 1'b1 || bus.xxx_write_en !== 8'h00 || bus.alu_op !== 3'd7) begin failures++; $display("FAIL ldiacc_wr got imm=%h drv=%b bl=%b wr=%h op=%0d exp 3C/1/1/00/7", bus.imm_data, bus.imm_drive, bus.alu_b_load, bus.xxx_write_en, bus.alu_op); end
    step();
    checks++; if (bus.xxx_write_en !== 8'h80 || bus.imm_drive !== 1'b0 || bus.alu_op !== 3'd7) begin failures++; $display("FAIL ldiacc_wb got wr=%h drv=%b op=%0d exp 80/0/7", bus.xxx_write_en, bus.imm_drive, bus.alu_op); end
    step();
  endtask

  task automatic test_nop();
    send(8'hC0);
    checks++; if (bus.busy !== 1'b0 || bus.instr_ready !== 1'b1 || bus.xxx_read_en !== 8'h00 || bus.xxx_write_en !== 8'h00) begin failures++; $display("FAIL nop got busy=%b rdy=%b rd=%h wr=%h exp 0/1/00/00", bus.busy, bus.instr_ready, bus.xxx_read_en, bus.xxx_write_en); end
  endtask

  task automatic test_reset_mid();
    send(8'h5B);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.xxx_read_en !== 8'h00 || bus.xxx_write_en !== 8'h00 || bus.alu_b_load !== 1'b0 || bus.busy !== 1'b0 || bus.instr_ready !== 1'b1 || bus.alu_op !== 3'd0) begin failures++; $display("FAIL reset_mid got rd=%h wr=%h bl=%b busy=%b rdy=%b op=%0d exp 00/00/0/0/1/0", bus.xxx_read_en, bus.xxx_write_en, bus.alu_b_load, bus.busy, bus.instr_ready, bus.alu_op); end
    step();
    checks++; if (bus.xxx_write_en !== 8'h00 || bus.busy !== 1'b0) begin failures++; $display("FAIL reset_mid_after got wr=%h busy=%b exp 00/0", bus.xxx_write_en, bus.busy); end
  endtask

  task automatic test_back_to_back();
    bus.instr_valid = 1'b1;
    bus.instr_data  = 8'h0A;
    step();
    checks++; if (bus.xxx_read_en !== 8'h04 || bus.instr_ready !== 1'b0) begin failures++; $display("FAIL b2b_first got rd=%h rdy=%b exp 04/0", bus.xxx_read_en, bus.instr_ready); end
    bus.instr_data = 8'h13;
    step();
    checks++; if (bus.instr_ready !== 1'b1 || bus.xxx_read_en !== 8'h00 || bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_gap got rdy=%b rd=%h busy=%b exp 1/00/0", bus.instr_ready, bus.xxx_read_en, bus.busy); end
    step();
    bus.instr_valid = 1'b0;
    checks++; if (bus.xxx_read_en !== 8'h08 || bus.xxx_write_en !== 8'h04) begin failures++; $display("FAIL b2b_second got rd=%h wr=%h exp 08/04", bus.xxx_read_en, bus.xxx_write_en); end
    step();
  endtask

  task automatic test_random_invariants();
    for (int i = 0; i < 400; i++) begin
      bus.instr_valid = ($urandom_range(0, 3) != 0);
      bus.instr_data  = 8'($urandom_range(0, 255));
      rst = ($urandom_range(0, 63) == 0);
      step();
      checks++; if (!$onehot0(bus.xxx_read_en)) begin failures++; $display("FAIL inv_read_onehot cycle=%0d got rd=%h exp zero or one-hot", i, bus.xxx_read_en); end
      checks++; if (!$onehot0(bus.xxx_write_en)) begin failures++; $display("FAIL inv_write_onehot cycle=%0d got wr=%h exp zero or one-hot", i, bus.xxx_write_en); end
      checks++; if (bus.imm_drive && (bus.xxx_read_en != 8'h00)) begin failures++; $display("FAIL inv_bus_clash cycle=%0d got drv=%b rd=%h exp no overlap", i, bus.imm_drive, bus.xxx_read_en); end
    end
    bus.instr_valid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_data  = 8'h00;
    test_reset();
    test_mov();
    test_mov_same();
    test_alu();
    test_ldi();
    test_mov_acc();
    test_ldi_acc();
    test_nop();
    test_reset_mid();
    test_back_to_back();
    test_random_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
